disparity_stream_framer: RTL

Framing stage placed directly upstream of the 3x1 horizontal bilateral filter. It takes the raw per-pixel stream from the block matcher (disparity, confidence, grayscale, start-of-frame marker) and counts pixel position. It emits the same pixel registered, with the `first_pixel_in_line`, `last_pixel_in_line` and `last_pixel_in_frame` tags the filter needs. It also gates low-confidence pixels, drops malformed input, and enforces a two-cycle post-frame drain so the filter's end-of-frame flush is never disturbed.

---
 rtl/disparity_stream_framer_if.sv | 33 +++
 rtl/disparity_stream_framer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/disparity_stream_framer_if.sv
// Pixel stream bundle between the block matcher, the framer and the bilateral filter.
// master drives the raw matcher pixel; slave is the framer producing the tagged pixel.
interface disparity_stream_framer_if #(
  parameter int disp_bits = 5
);
  logic [disp_bits-1:0] disparity_in;
  logic [7:0]           confidence_in;
  logic [7:0]           gray_in;
  logic                 sof_in;
  logic                 in_valid;

  logic [disp_bits-1:0] disparity_out;
  logic [7:0]           confidence_out;
  logic [7:0]           gray_out;
  logic                 first_pixel_in_line;
  logic                 last_pixel_in_line;
  logic                 last_pixel_in_frame;
  logic                 out_valid;
  logic                 frame_error;
  logic                 busy;

  modport master (
    output disparity_in, confidence_in, gray_in, sof_in, in_valid,
    input  disparity_out, confidence_out, gray_out, first_pixel_in_line,
           last_pixel_in_line, last_pixel_in_frame, out_valid, frame_error, busy
  );

  modport slave (
    input  disparity_in, confidence_in, gray_in, sof_in, in_valid,
    output disparity_out, confidence_out, gray_out, first_pixel_in_line,
           last_pixel_in_line, last_pixel_in_frame, out_valid, frame_error, busy
  );
endinterface

// File: rtl/disparity_stream_framer.sv
// Tags the matcher pixel stream with line/frame position ahead of the bilateral filter.
// Optional DISPARITY_FRAMER_STATS_EN adds frame_count and error_count outputs.
module disparity_stream_framer #(
  parameter int disp_bits    = 5,
  parameter int line_width   = 640,
  parameter int frame_height = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  conf_min,
  disparity_stream_framer_if.slave bus
`ifdef DISPARITY_FRAMER_STATS_EN
  ,
  output logic [15:0] frame_count,
  output logic [15:0] error_count
`endif
);

  localparam int XW = (line_width   > 1) ? $clog2(line_width)   : 1;
  localparam int YW = (frame_height > 1) ? $clog2(frame_height) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(line_width - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(frame_height - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [XW-1:0]   r_xPos, w_nextX;
  logic [YW-1:0]   r_yPos, w_nextY;
  logic [1:0]      r_drainCnt, w_nextDrain;

  logic            w_emit;
  logic            w_first;
  logic            w_lastLine;
  logic            w_lastFrame;
  logic            w_error;
  logic            w_atOrigin;
  logic            w_gated;

  logic [disp_bits-1:0] r_dispOut;
  logic [7:0]           r_confOut;
  logic [7:0]           r_grayOut;
  logic                 r_first;
  logic                 r_lastLine;
  logic                 r_lastFrame;
  logic                 r_outValid;
  logic                 r_frameError;
  logic                 r_busy;

  assign w_atOrigin = (r_xPos == '0) && (r_yPos == '0);
  assign w_gated    = bus.confidence_in < conf_min;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_xPos     <= '0;
      r_yPos     <= '0;
      r_drainCnt <= '0;
    end else begin
      r_state    <= w_nextState;
      r_xPos     <= w_nextX;
      r_yPos     <= w_nextY;
      r_drainCnt <= w_nextDrain;
    end
  end

  // A mid-frame sof restarts the frame in place: the pixel becomes (0,0) and the error is flagged.
  always_comb begin
    w_nextState = r_state;
    w_nextX     = r_xPos;
    w_nextY     = r_yPos;
    w_nextDrain = r_drainCnt;
    w_emit      = 1'b0;
    w_first     = 1'b0;
    w_lastLine  = 1'b0;
    w_lastFrame = 1'b0;
    w_error     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.sof_in) begin
            w_emit      = 1'b1;
            w_first     = 1'b1;
            w_nextX     = XW'(1);
            w_nextY     = '0;
            w_nextState = ACTIVE;
          end else begin
            w_error = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (bus.in_valid) begin
          w_emit = 1'b1;
          if (bus.sof_in && !w_atOrigin) begin
            w_first = 1'b1;
            w_error = 1'b1;
            w_nextX = XW'(1);
            w_nextY = '0;
          end else begin
            w_first = (r_xPos == '0);
            if (r_xPos == X_LAST) begin
              w_lastLine = 1'b1;
              w_nextX    = '0;
              if (r_yPos == Y_LAST) begin
                w_lastFrame = 1'b1;
                w_nextY     = '0;
                w_nextDrain = 2'd2;
                w_nextState = DRAIN;
              end else begin
                w_nextY = r_yPos + YW'(1);
              end
            end else begin
              w_nextX = r_xPos + XW'(1);
            end
          end
        end
      end
      DRAIN: begin
        w_error = bus.in_valid;
        if (r_drainCnt == 2'd1) begin
          w_nextState = IDLE;
          w_nextDrain = '0;
        end else begin
          w_nextDrain = r_drainCnt - 2'd1;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Everything leaving the block is registered; idle cycles present all-zero data and tags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dispOut    <= '0;
      r_confOut    <= '0;
      r_grayOut    <= '0;
      r_first      <= 1'b0;
      r_lastLine   <= 1'b0;
      r_lastFrame  <= 1'b0;
      r_outValid   <= 1'b0;
      r_frameError <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_dispOut    <= (w_emit && !w_gated) ? bus.disparity_in  : '0;
      r_confOut    <= (w_emit && !w_gated) ? bus.confidence_in : '0;
      r_grayOut    <= w_emit ? bus.gray_in : '0;
      r_first      <= w_first;
      r_lastLine   <= w_lastLine;
      r_lastFrame  <= w_lastFrame;
      r_outValid   <= w_emit;
      r_frameError <= w_error;
      r_busy       <= (w_nextState != IDLE);
    end
  end

  assign bus.disparity_out       = r_dispOut;
  assign bus.confidence_out      = r_confOut;
  assign bus.gray_out            = r_grayOut;
  assign bus.first_pixel_in_line = r_first;
  assign bus.last_pixel_in_line  = r_lastLine;
  assign bus.last_pixel_in_frame = r_lastFrame;
  assign bus.out_valid           = r_outValid;
  assign bus.frame_error         = r_frameError;
  assign bus.busy                = r_busy;

`ifdef DISPARITY_FRAMER_STATS_EN
  logic [15:0] r_frameCount;
  logic [15:0] r_errorCount;

  // Frames count on entry to DRAIN; errors saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frameCount <= '0;
      r_errorCount <= '0;
    end else begin
      if (r_state == ACTIVE && w_nextState == DRAIN) begin
        r_frameCount <= r_frameCount + 16'd1;
      end
      if (w_error && r_errorCount != 16'hFFFF) begin
        r_errorCount <= r_errorCount + 16'd1;
      end
    end
  end

  assign frame_count = r_frameCount;
  assign error_count = r_errorCount;
`endif

endmodule
